random_gap_throttle: RTL
========================

Name: random_gap_throttle

Overview:
- Valid/ready stream gate that inserts a random number of closed cycles after every accepted beat.
- Consumes the value of the adjacent constrained-random generator (RAND) and drives that generator's enable (RAND_EN) to draw a fresh value per beat.
- Sits between a stimulus producer and the DUT in randomized-backpressure test harnesses.
- Keeps transfer and stall counters for coverage reporting.

Parameters:
- dwidth, 32, stream data width.
- rwidth, 8, width of RAND and of the internal gap counter; RAND is unsigned.
- cwidth, 32, width of the XFER_COUNT and STALL_COUNT statistics counters.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  reset; asynchronous and active-high.
- THROTTLE_EN  input  1  when 1, gaps are inserted; when 0, the block is transparent.
- CLEAR  input  1  synchronous clear of the statistics counters.
- IN_VALID  input  1  upstream beat valid.
- IN_READY  output  1  upstream beat accepted.
- IN_DATA  input  dwidth  upstream data.
- OUT_VALID  output  1  downstream valid.
- OUT_READY  input  1  downstream ready.
- OUT_DATA  output  dwidth  downstream data.
- RAND  input  rwidth  current random gap value from the generator.
- RAND_EN  output  1  one-cycle draw strobe to the generator.
- XFER_COUNT  output  cwidth  number of beats transferred.
- STALL_COUNT  output  cwidth  number of HOLD cycles with IN_VALID=1.
- GATE_OPEN  output  1  1 when the state is OPEN.

Behaviour:
- State machine has two states: OPEN and HOLD. Internal gap counter cnt[rwidth-1:0].
- Reset (RST=1, asynchronous): state=OPEN, cnt=0, XFER_COUNT=0, STALL_COUNT=0.
  - While RST=1: OUT_VALID=0, IN_READY=0, RAND_EN=0, GATE_OPEN=0.
- OUT_DATA=IN_DATA combinationally at all times. No data register; latency is 0 cycles.
- In OPEN: OUT_VALID=IN_VALID and IN_READY=OUT_READY, both combinational.
  - A transfer (xfer) is IN_VALID & OUT_READY in OPEN.
- On xfer with THROTTLE_EN=1:
  - RAND_EN=1 in that same cycle, so the generator advances at that edge.
  - If RAND!=0: next state=HOLD, cnt<=RAND.
  - If RAND==0: stay in OPEN, which allows back-to-back beats.
- On xfer with THROTTLE_EN=0: RAND_EN=0 and the state stays OPEN.
- The gap is always the RAND value present in the transfer cycle. The first gap after reset equals the generator's reset value.
- In HOLD:
  - OUT_VALID=0 and IN_READY=0 regardless of the handshake inputs. RAND_EN=0.
  - cnt decrements each cycle. When cnt==1, next state=OPEN and cnt<=0.
  - The gate is therefore closed for exactly RAND cycles: a beat at cycle t gives first re-open at t+1+RAND.
- THROTTLE_EN falling while in HOLD: next state=OPEN and cnt<=0 at the next edge (gap aborted).
- THROTTLE_EN changes take effect for the xfer decision in the same cycle.
- XFER_COUNT increments by 1 on each xfer. STALL_COUNT increments by 1 on each HOLD cycle with IN_VALID=1.
  - Both counters wrap modulo 2^cwidth.
  - CLEAR=1 sets both to 0 at the next edge and has priority over a simultaneous increment.
- RST asserted mid-gap: immediately OPEN and cnt=0; the first cycle after release is open.
- RAND at maximum (2^rwidth-1): the gate is closed for 2^rwidth-1 cycles. There is no wrap of cnt.

Test Plan:
- Reset release, THROTTLE_EN=0, IN_VALID=OUT_READY=1 for 10 cycles: 10 beats, RAND_EN never asserted, XFER_COUNT=10, STALL_COUNT=0.
- THROTTLE_EN=1, RAND held at 3, continuous traffic: beats at cycles 0,4,8,12; RAND_EN high exactly in those cycles; STALL_COUNT increments 3 per gap.
- RAND=0 on every draw: beat every cycle with RAND_EN high every cycle, and GATE_OPEN stays 1.
- RAND=5 at beat in cycle 0, THROTTLE_EN dropped in cycle 2: gate reopens in cycle 3 and the next beat is accepted in cycle 3.
- RST pulsed in cycle 2 of a RAND=200 gap: outputs forced low during RST, counters=0, and a beat is accepted in the first cycle after release.
- CLEAR asserted in a cycle with an xfer: XFER_COUNT reads 0 next cycle, not 1.
- OUT_READY=0 with IN_VALID=1 in OPEN: no xfer, no RAND_EN, state stays OPEN, counters unchanged.

Source files
------------

// File: rtl/random_gap_throttle.sv
// Valid/ready stream gate that closes for a random number of cycles after each
// accepted beat, drawing the gap length from an external random generator.
module random_gap_throttle #(
  parameter int dwidth = 32,
  parameter int rwidth = 8,
  parameter int cwidth = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              THROTTLE_EN,
  input  logic              CLEAR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [dwidth-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [dwidth-1:0] OUT_DATA,
  input  logic [rwidth-1:0] RAND,
  output logic              RAND_EN,
  output logic [cwidth-1:0] XFER_COUNT,
  output logic [cwidth-1:0] STALL_COUNT,
  output logic              GATE_OPEN
);

  typedef enum logic {
    OPEN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [rwidth-1:0] cnt_q, cnt_d;
  logic [cwidth-1:0] xferCount_q, xferCount_d;
  logic [cwidth-1:0] stallCount_q, stallCount_d;

  logic gateOpen;
  logic xfer;
  logic stall;

  // Handshake outputs are forced low while reset is held, not only after it.
  assign gateOpen  = (state_q == OPEN) && !RST;
  assign xfer      = gateOpen && IN_VALID && OUT_READY;
  assign stall     = (state_q == HOLD) && IN_VALID;

  assign OUT_DATA  = IN_DATA;
  assign OUT_VALID = gateOpen && IN_VALID;
  assign IN_READY  = gateOpen && OUT_READY;
  assign RAND_EN   = xfer && THROTTLE_EN;
  assign GATE_OPEN = gateOpen;

  assign XFER_COUNT  = xferCount_q;
  assign STALL_COUNT = stallCount_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= OPEN;
      cnt_q        <= '0;
      xferCount_q  <= '0;
      stallCount_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xferCount_q  <= xferCount_d;
      stallCount_q <= stallCount_d;
    end
  end

  // A gap of RAND cycles: HOLD is entered with cnt=RAND and left when cnt reaches 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OPEN: begin
        if (xfer && THROTTLE_EN && (RAND != '0)) begin
          state_d = HOLD;
          cnt_d   = RAND;
        end
      end
      HOLD: begin
        if (!THROTTLE_EN || (cnt_q == rwidth'(1))) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - rwidth'(1);
        end
      end
      default: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    xferCount_d  = xferCount_q;
    stallCount_d = stallCount_q;
    if (CLEAR) begin
      xferCount_d  = '0;
      stallCount_d = '0;
    end else begin
      if (xfer) xferCount_d = xferCount_q + cwidth'(1);
      if (stall) stallCount_d = stallCount_q + cwidth'(1);
    end
  end

endmodule
